// File: rtl/ysyx_22040759_wb_arb_pkg.sv
// rtl/ysyx_22040759_wb_arb_pkg.sv - shared widths, writeback source encodings and x0 constant
package ysyx_22040759_wb_arb_pkg;

    localparam int WB_XLEN        = 32;
    localparam int REG_AW         = 5;
    localparam int NREG_DEF       = 32;
    localparam int STARVE_LIM_DEF = 4;

    // Which producer owns the single GPR write port this cycle
    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

    localparam logic [REG_AW-1:0] REG_X0 = '0;

    // x0 is never written and never tracked as pending
    function automatic logic is_x0(input logic [REG_AW-1:0] addr);
        return addr == REG_X0;
    endfunction

endpackage

// File: rtl/ysyx_22040759_scoreboard.sv
// rtl/ysyx_22040759_scoreboard.sv - per-GPR busy bits with two query ports; bypass mask under YSYX_22040759_WB_BYPASS_EN
module ysyx_22040759_scoreboard
    import ysyx_22040759_wb_arb_pkg::*;
#(
    parameter int XLEN = WB_XLEN,
    parameter int NREG = NREG_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_addr,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_addr,
    input  logic [XLEN-1:0]   clr_data,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [XLEN-1:0]   rs1_fwd_data,
    output logic [XLEN-1:0]   rs2_fwd_data
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    function automatic logic in_range(input logic [REG_AW-1:0] a);
        return !is_x0(a) && (int'(a) < NREG);
    endfunction

    function automatic logic lookup(input logic [NREG-1:0] v, input logic [REG_AW-1:0] a);
        return in_range(a) ? v[a] : 1'b0;
    endfunction

    // Clear on the landed RF write first, then apply issue so a same-edge set wins
    always_comb begin
        busy_d = busy_q;
        if (clr_en && in_range(clr_addr)) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en && in_range(set_addr)) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

`ifdef YSYX_22040759_WB_BYPASS_EN
    logic hit1;
    logic hit2;
    assign hit1 = clr_en && !is_x0(rs1_addr) && (clr_addr == rs1_addr);
    assign hit2 = clr_en && !is_x0(rs2_addr) && (clr_addr == rs2_addr);

    // A write landing this cycle satisfies the query; the IDU takes the forwarded value
    always_comb begin
        rs1_busy     = lookup(busy_q, rs1_addr) && !hit1;
        rs2_busy     = lookup(busy_q, rs2_addr) && !hit2;
        rs1_fwd_data = hit1 ? clr_data : '0;
        rs2_fwd_data = hit2 ? clr_data : '0;
    end
`else
    logic unused_clr_data;
    assign unused_clr_data = ^clr_data;

    // Without forwarding the source stays pending until the write has landed in the RF
    always_comb begin
        rs1_busy     = lookup(busy_q, rs1_addr);
        rs2_busy     = lookup(busy_q, rs2_addr);
        rs1_fwd_data = '0;
        rs2_fwd_data = '0;
    end
`endif

endmodule

// File: rtl/ysyx_22040759_wb_arb.sv
// rtl/ysyx_22040759_wb_arb.sv - ALU/LSU writeback arbiter with starvation guard; bypass via YSYX_22040759_WB_BYPASS_EN
module ysyx_22040759_wb_arb
    import ysyx_22040759_wb_arb_pkg::*;
#(
    parameter int XLEN       = WB_XLEN,
    parameter int NREG       = NREG_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_wdata,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_wdata,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic [REG_AW-1:0] rs1_addr,
    output logic              rs1_busy,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              rs2_busy,
    output logic [XLEN-1:0]   rs1_fwd_data,
    output logic [XLEN-1:0]   rs2_fwd_data,
    output logic              gpr_wen,
    output logic [REG_AW-1:0] gpr_waddr,
    output logic [XLEN-1:0]   gpr_wdata
);

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

    logic [SW-1:0]     starve_q;
    logic [SW-1:0]     starve_d;
    logic              gpr_wen_q;
    logic              gpr_wen_d;
    logic [REG_AW-1:0] gpr_waddr_q;
    logic [REG_AW-1:0] gpr_waddr_d;
    logic [XLEN-1:0]   gpr_wdata_q;
    logic [XLEN-1:0]   gpr_wdata_d;

    logic              grant_alu;
    logic              grant_lsu;
    wb_src_e           win_src;
    logic [REG_AW-1:0] win_rd;
    logic [XLEN-1:0]   win_data;

    // LSU wins by default; ALU wins when the LSU is idle or it has lost STARVE_LIM times in a row
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        win_src   = WB_SRC_LSU;
        if (rst_n) begin
            if (alu_valid && (!lsu_valid || (starve_q == LIM))) begin
                grant_alu = 1'b1;
                win_src   = WB_SRC_ALU;
            end else if (lsu_valid) begin
                grant_lsu = 1'b1;
            end
        end
    end

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;
    assign win_rd    = (win_src == WB_SRC_ALU) ? alu_rd    : lsu_rd;
    assign win_data  = (win_src == WB_SRC_ALU) ? alu_wdata : lsu_wdata;

    // Starvation counter and next writeback stage contents
    always_comb begin
        starve_d    = starve_q;
        gpr_wen_d   = 1'b0;
        gpr_waddr_d = gpr_waddr_q;
        gpr_wdata_d = gpr_wdata_q;
        if (grant_alu) begin
            starve_d = '0;
        end else if (alu_valid && (starve_q != LIM)) begin
            starve_d = starve_q + 1'b1;
        end
        if (grant_alu || grant_lsu) begin
            // x0 destinations complete the handshake but never raise the write enable
            gpr_wen_d   = !is_x0(win_rd);
            gpr_waddr_d = win_rd;
            gpr_wdata_d = win_data;
        end
    end

    // Arbiter state and registered writeback stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q    <= '0;
            gpr_wen_q   <= 1'b0;
            gpr_waddr_q <= '0;
            gpr_wdata_q <= '0;
        end else begin
            starve_q    <= starve_d;
            gpr_wen_q   <= gpr_wen_d;
            gpr_waddr_q <= gpr_waddr_d;
            gpr_wdata_q <= gpr_wdata_d;
        end
    end

    assign gpr_wen   = gpr_wen_q;
    assign gpr_waddr = gpr_waddr_q;
    assign gpr_wdata = gpr_wdata_q;

    ysyx_22040759_scoreboard #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_en       (iss_valid),
        .set_addr     (iss_rd),
        .clr_en       (gpr_wen_q),
        .clr_addr     (gpr_waddr_q),
        .clr_data     (gpr_wdata_q),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rs1_fwd_data (rs1_fwd_data),
        .rs2_fwd_data (rs2_fwd_data)
    );

endmodule

// File: tb/tb_ysyx_22040759_wb_arb.sv
// tb/tb_ysyx_22040759_wb_arb.sv - randomized bench with behavioural writeback/scoreboard model
module tb_ysyx_22040759_wb_arb;

    localparam int STARVE_LIM = 4;
`ifdef YSYX_22040759_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0, lsu_valid = 1'b0, iss_valid = 1'b0;
    logic [4:0]  alu_rd = '0, lsu_rd = '0, iss_rd = '0, rs1_addr = '0, rs2_addr = '0;
    logic [31:0] alu_wdata = '0, lsu_wdata = '0;
    logic        alu_ready, lsu_ready, rs1_busy, rs2_busy, gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] rs1_fwd_data, rs2_fwd_data, gpr_wdata;

    int total_cnt = 0;
    int pass_cnt  = 0;

    // behavioural model state
    bit          m_busy [32];
    int          m_starve = 0;
    bit          m_wen = 0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    bit          m_alu_acc = 0, m_lsu_acc = 0;

    always #5 clk = ~clk;

    ysyx_22040759_wb_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_wdata    (alu_wdata),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_wdata    (lsu_wdata),
        .iss_valid    (iss_valid),
        .iss_rd       (iss_rd),
        .rs1_addr     (rs1_addr),
        .rs1_busy     (rs1_busy),
        .rs2_addr     (rs2_addr),
        .rs2_busy     (rs2_busy),
        .rs1_fwd_data (rs1_fwd_data),
        .rs2_fwd_data (rs2_fwd_data),
        .gpr_wen      (gpr_wen),
        .gpr_waddr    (gpr_waddr),
        .gpr_wdata    (gpr_wdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit m_alu_wins();
        return rst_n && alu_valid && (!lsu_valid || m_starve == STARVE_LIM);
    endfunction

    function automatic bit m_src_busy(input logic [4:0] a);
        if (a == 0) return 0;
        if (BYPASS && m_wen && m_waddr == a) return 0;
        return m_busy[a];
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] a);
        if (BYPASS && a != 0 && m_wen && m_waddr == a) return m_wdata;
        return 32'h0;
    endfunction

    // model: what the port rules say happens at each edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_starve = 0; m_wen = 0; m_waddr = '0; m_wdata = '0;
            m_alu_acc = 0; m_lsu_acc = 0;
        end else begin
            m_alu_acc = m_alu_wins();
            m_lsu_acc = lsu_valid && !m_alu_acc;
            if (iss_valid && iss_rd != 0)
                assert (!m_busy[iss_rd]) else $error("FAIL waw_issue: rd %0d already busy", iss_rd);
            if (m_wen && m_waddr != 0) m_busy[m_waddr] = 0;
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
            if (m_alu_acc) m_starve = 0;
            else if (alu_valid && m_starve < STARVE_LIM) m_starve++;
            if (m_alu_acc) begin
                m_wen = (alu_rd != 0); m_waddr = alu_rd; m_wdata = alu_wdata;
            end else if (m_lsu_acc) begin
                m_wen = (lsu_rd != 0); m_waddr = lsu_rd; m_wdata = lsu_wdata;
            end else begin
                m_wen = 0;
            end
        end
    end

    // compare process: every output, every cycle, away from the active edge
    always @(negedge clk) begin
        bit ea;
        ea = m_alu_wins();
        chk("alu_ready", alu_ready, ea);
        chk("lsu_ready", lsu_ready, rst_n && lsu_valid && !ea);
        chk("gpr_wen", gpr_wen, m_wen);
        chk("gpr_waddr", gpr_waddr, m_waddr);
        chk("gpr_wdata", gpr_wdata, m_wdata);
        chk("rs1_busy", rs1_busy, m_src_busy(rs1_addr));
        chk("rs2_busy", rs2_busy, m_src_busy(rs2_addr));
        chk("rs1_fwd", rs1_fwd_data, m_fwd(rs1_addr));
        chk("rs2_fwd", rs2_fwd_data, m_fwd(rs2_addr));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset: ready must stay low even with a pending request
        alu_valid = 1'b1; alu_rd = 5'd1; alu_wdata = 32'h1;
        @(negedge clk);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_gpr_wen", gpr_wen, 0);
        alu_valid = 1'b0;
        step();
        rst_n = 1'b1;

        // 1 single ALU write
        alu_valid = 1; alu_rd = 5; alu_wdata = 32'h1234;
        @(negedge clk); chk("t1_ready", alu_ready, 1);
        step(); alu_valid = 0;
        @(negedge clk);
        chk("t1_wen", gpr_wen, 1); chk("t1_waddr", gpr_waddr, 5); chk("t1_wdata", gpr_wdata, 32'h1234);

        // 2 contention: LSU first, ALU the cycle after
        step();
        alu_valid = 1; alu_rd = 4; alu_wdata = 32'hBB;
        lsu_valid = 1; lsu_rd = 3; lsu_wdata = 32'hAA;
        @(negedge clk); chk("t2_lsu_ready", lsu_ready, 1); chk("t2_alu_ready", alu_ready, 0);
        step(); lsu_valid = 0;
        @(negedge clk);
        chk("t2_waddr_lsu", gpr_waddr, 3); chk("t2_wdata_lsu", gpr_wdata, 32'hAA);
        chk("t2_alu_ready2", alu_ready, 1);
        step(); alu_valid = 0;
        @(negedge clk); chk("t2_waddr_alu", gpr_waddr, 4); chk("t2_wdata_alu", gpr_wdata, 32'hBB);

        // 3 starvation: ALU forced through on the 5th contended cycle
        step();
        alu_valid = 1; alu_rd = 10; alu_wdata = 32'hA0;
        lsu_valid = 1; lsu_rd = 11; lsu_wdata = 32'hB0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t3_alu_ready", alu_ready, (i == 4));
            chk("t3_lsu_ready", lsu_ready, (i != 4));
            step();
            if (i == 4) alu_wdata = 32'hA1;
            else lsu_wdata = lsu_wdata + 1;
        end
        lsu_valid = 0;
        @(negedge clk); chk("t3_alu_after", alu_ready, 1);
        step(); alu_valid = 0;

        // 4 scoreboard on rd=7
        iss_valid = 1; iss_rd = 7; rs1_addr = 7;
        step(); iss_valid = 0;
        @(negedge clk); chk("t4_busy_set", rs1_busy, 1);
        alu_valid = 1; alu_rd = 7; alu_wdata = 32'h77;
        step(); alu_valid = 0;
        @(negedge clk);
        chk("t4_wen", gpr_wen, 1);
        chk("t4_busy_wcyc", rs1_busy, BYPASS ? 0 : 1);
        chk("t4_fwd", rs1_fwd_data, BYPASS ? 32'h77 : 32'h0);
        step();
        @(negedge clk); chk("t4_busy_clr", rs1_busy, 0);

        // 5 x0 destination
        alu_valid = 1; alu_rd = 0; alu_wdata = 32'hFFFF;
        @(negedge clk); chk("t5_ready", alu_ready, 1);
        step(); alu_valid = 0; iss_valid = 1; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
        @(negedge clk); chk("t5_wen", gpr_wen, 0);
        step(); iss_valid = 0;
        @(negedge clk); chk("t5_busy0", rs1_busy, 0);

        // 6 async reset with a write in flight and a busy register
        iss_valid = 1; iss_rd = 9; rs2_addr = 9;
        step(); iss_valid = 0;
        alu_valid = 1; alu_rd = 9; alu_wdata = 32'h99;
        step(); alu_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("t6_wen", gpr_wen, 0); chk("t6_waddr", gpr_waddr, 0);
        chk("t6_wdata", gpr_wdata, 0); chk("t6_busy", rs2_busy, 0);
        step(); rst_n = 1;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            step();
            if (!alu_valid || m_alu_acc) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_rd = 5'($urandom); alu_wdata = $urandom;
            end
            if (!lsu_valid || m_lsu_acc) begin
                lsu_valid = ($urandom_range(0, 9) < 6);
                lsu_rd = 5'($urandom); lsu_wdata = $urandom;
            end
            r = $urandom_range(0, 31);
            iss_rd = 5'(r);
            iss_valid = ($urandom_range(0, 1) == 1) && !m_busy[r];
            rs1_addr = $urandom_range(0, 1) ? m_waddr : 5'($urandom);
            rs2_addr = $urandom_range(0, 1) ? m_waddr : 5'($urandom);
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
